// File: rtl/serial_subtractor_pkg.sv
// ============================================================================
// Module  : sub_pkg
// Brief   : Shared types and constants for the bit-serial subtractor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sub_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int SUB_WIDTH_DEF = 8;

endpackage : sub_pkg

`default_nettype wire

// File: rtl/serial_subtractor_if.sv
// ============================================================================
// Module  : serial_subtractor_if
// Brief   : Request/result bundle for serial_subtractor. With SERIAL_SUB_OVF_EN
//           defined, it also carries the signed-overflow flag ovf.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_subtractor_if
   import sub_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH_DEF
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf;

   modport master (output start, a, b, input busy, done, diff, borrow, ovf);
   modport slave  (input start, a, b, output busy, done, diff, borrow, ovf);
`else
   modport master (output start, a, b, input busy, done, diff, borrow);
   modport slave  (input start, a, b, output busy, done, diff, borrow);
`endif

endinterface : serial_subtractor_if

`default_nettype wire

// File: rtl/serial_subtractor_half_subtractor.sv
// ============================================================================
// Module  : half_subtractor
// Brief   : Combinational half subtractor: Diff = A ^ B, Borrow = ~A & B.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module half_subtractor (
   input  wire logic A,
   input  wire logic B,
   output logic      Diff,
   output logic      Borrow
);

   assign Diff   = A ^ B;
   assign Borrow = ~A & B;

endmodule : half_subtractor

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module  : serial_subtractor
// Brief   : Bit-serial unsigned subtractor, diff = a - b over WIDTH cycles,
//           LSB first. Optional macro SERIAL_SUB_OVF_EN adds a signed ovf flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
   import sub_pkg::*;
#(
   parameter int WIDTH = SUB_WIDTH_DEF
) (
   input  wire logic          clk,
   input  wire logic          rst,
   serial_subtractor_if.slave bus
);

   localparam int             CW       = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

   state_t           state, state_next;
   logic [WIDTH-1:0] a_sh, b_sh, d_sh;
   logic [CW-1:0]    cnt;
   logic             bw;
   logic             done_r;
   logic [WIDTH-1:0] diff_r;
   logic             borrow_r;

   logic             load, shift, finish;
   logic             d_bit, bw_next;
   logic             hs1_diff, hs1_borrow, hs2_borrow;

   // Full-subtractor cell: two half subtractors, borrows ORed.
   half_subtractor u_hs1 (
      .A      (a_sh[0]),
      .B      (b_sh[0]),
      .Diff   (hs1_diff),
      .Borrow (hs1_borrow)
   );

   half_subtractor u_hs2 (
      .A      (hs1_diff),
      .B      (bw),
      .Diff   (d_bit),
      .Borrow (hs2_borrow)
   );

   assign bw_next = hs1_borrow | hs2_borrow;

   always_comb begin
      state_next = state;
      load       = 1'b0;
      shift      = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            shift = 1'b1;
            if (cnt == LAST_CNT) begin
               finish     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         a_sh     <= '0;
         b_sh     <= '0;
         d_sh     <= '0;
         cnt      <= '0;
         bw       <= 1'b0;
         done_r   <= 1'b0;
         diff_r   <= '0;
         borrow_r <= 1'b0;
      end else begin
         state  <= state_next;
         done_r <= finish;
         if (load) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            d_sh <= '0;
            cnt  <= '0;
            bw   <= 1'b0;
         end else if (shift) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            d_sh <= {d_bit, d_sh[WIDTH-1:1]};
            cnt  <= cnt + CW'(1);
            bw   <= bw_next;
         end
         if (finish) begin
            diff_r   <= {d_bit, d_sh[WIDTH-1:1]};
            borrow_r <= bw_next;
         end
      end
   end

   assign bus.busy   = (state == RUN);
   assign bus.done   = done_r;
   assign bus.diff   = diff_r;
   assign bus.borrow = borrow_r;

`ifdef SERIAL_SUB_OVF_EN
   // Operand MSBs are shifted out during RUN, so keep copies for the ovf term.
   logic a_msb, b_msb, ovf_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         ovf_r <= 1'b0;
      end else begin
         if (load) begin
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
         end
         if (finish) begin
            ovf_r <= (a_msb != b_msb) && (d_bit != a_msb);
         end
      end
   end

   assign bus.ovf = ovf_r;
`endif

endmodule : serial_subtractor

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module  : tb_serial_subtractor
// Brief   : Self-checking bench for serial_subtractor (WIDTH=8); honours
//           SERIAL_SUB_OVF_EN when defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   serial_subtractor_if #(.WIDTH(W)) sif ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (sif.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Starts an operation at the current negedge, then stops at the negedge
   // where done is seen (or after a bounded wait).
   task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] exp_d, input logic exp_bw,
                        input logic exp_ovf, input string tag);
      int cyc;
      sif.start = 1'b1;
      sif.a     = av;
      sif.b     = bv;
      @(negedge clk);
      sif.start = 1'b0;
      check({tag, " busy"}, 32'(sif.busy), 32'd1);
      cyc = 0;
      while (!sif.done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, " latency"}, 32'(cyc), 32'd8);
      check({tag, " diff"}, 32'(sif.diff), 32'(exp_d));
      check({tag, " borrow"}, 32'(sif.borrow), 32'(exp_bw));
      check({tag, " busy@done"}, 32'(sif.busy), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      check({tag, " ovf"}, 32'(sif.ovf), 32'(exp_ovf));
`else
      if (exp_ovf === 1'bz) $display("unused");
`endif
   endtask

   initial begin
      int cyc;
      int ndone;
      logic [7:0] ra, rb, ed;
      logic       eo;

      sif.start = 1'b0;
      sif.a     = '0;
      sif.b     = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("reset busy", 32'(sif.busy), 32'd0);
      check("reset done", 32'(sif.done), 32'd0);
      check("reset diff", 32'(sif.diff), 32'd0);
      check("reset borrow", 32'(sif.borrow), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      check("reset ovf", 32'(sif.ovf), 32'd0);
`endif

      do_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "basic");
      @(negedge clk);
      check("done one cycle", 32'(sif.done), 32'd0);
      check("diff held", 32'(sif.diff), 32'h02);
      do_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "neg");
      do_op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, "0-ff");
      do_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, "zero");
      do_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "ovf1");
      do_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "ovf2");

      // Busy collision: a second start mid-run must be ignored.
      @(negedge clk);
      sif.start = 1'b1; sif.a = 8'h10; sif.b = 8'h01;
      @(negedge clk);
      sif.start = 1'b0;
      repeat (2) @(negedge clk);
      sif.start = 1'b1; sif.a = 8'hAA; sif.b = 8'h55;
      @(negedge clk);
      sif.start = 1'b0;
      cyc = 0; ndone = 0;
      while (ndone == 0 && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (sif.done) ndone++;
      end
      check("collision latency", 32'(cyc), 32'd5);
      check("collision diff", 32'(sif.diff), 32'h0F);
      check("collision borrow", 32'(sif.borrow), 32'd0);
      do_op(8'hAA, 8'h55, 8'h55, 1'b0, 1'b1, "b2b");

      // Reset mid-operation aborts without a done pulse.
      @(negedge clk);
      sif.start = 1'b1; sif.a = 8'h80; sif.b = 8'h01;
      @(negedge clk);
      sif.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort busy", 32'(sif.busy), 32'd0);
      check("abort diff", 32'(sif.diff), 32'd0);
      check("abort borrow", 32'(sif.borrow), 32'd0);
      ndone = 0;
      repeat (10) begin
         @(negedge clk);
         if (sif.done) ndone++;
      end
      check("abort no done", 32'(ndone), 32'd0);

      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         ed = ra - rb;
         eo = (ra[7] != rb[7]) && (ed[7] != ra[7]);
         do_op(ra, rb, ed, (ra < rb), eo, "rand");
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_serial_subtractor

`default_nettype wire
